// File: rtl/nf_router_ctrl_if.sv
// nf_router_ctrl_if: master-side and slave-side bundles of the router.
// SLAVE_NUMBER sets the slave port count (default 4).
`ifndef SLAVE_NUMBER
`define SLAVE_NUMBER 4
`endif

interface nf_router_ctrl_if #(
  parameter int SLAVE_N = `SLAVE_NUMBER
);
  logic [31:0]          addr_m;
  logic                 we_m;
  logic [31:0]          wd_m;
  logic                 req_m;
  logic                 ack_m;
  logic [31:0]          rd_m;
  logic                 err_m;
  logic [SLAVE_N-1:0]   slave_sel;
  logic [31:0]          addr_s;
  logic                 we_s;
  logic [31:0]          wd_s;
  logic [SLAVE_N-1:0]   req_s;
  logic [SLAVE_N-1:0]   ack_s;
  logic [32*SLAVE_N-1:0] rd_s;

  modport ctrl (
    input  addr_m, we_m, wd_m, req_m,
    input  slave_sel, ack_s, rd_s,
    output ack_m, rd_m, err_m,
    output addr_s, we_s, wd_s, req_s
  );

  modport master (
    output addr_m, we_m, wd_m, req_m,
    output slave_sel,
    input  ack_m, rd_m, err_m
  );

  modport slave (
    input  addr_s, we_s, wd_s, req_s,
    output ack_s, rd_s
  );
endinterface

// File: rtl/nf_router_ctrl.sv
// nf_router_ctrl: one-in-flight load/store router to one-hot slaves.
// Optional BUSY timeout enabled by defining NF_ROUTER_TIMEOUT_EN.
`ifndef SLAVE_NUMBER
`define SLAVE_NUMBER 4
`endif

module nf_router_ctrl #(
  parameter int          SLAVE_N   = `SLAVE_NUMBER,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input logic             clk,
  input logic             resetn,
  nf_router_ctrl_if.ctrl  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    ERR
  } state_e;

  state_e             state_q;
  logic [SLAVE_N-1:0] sel_q;
  logic [SLAVE_N-1:0] req_s_q;
  logic [31:0]        addr_q;
  logic               we_q;
  logic [31:0]        wd_q;
  logic [31:0]        rd_q;
`ifdef NF_ROUTER_TIMEOUT_EN
  logic [7:0]         cnt_q;
`endif

  logic        one_hot;
  logic        ack_hit;
  logic [31:0] rd_pick;

  assign one_hot = ($countones(bus.slave_sel) == 1);
  assign ack_hit = |(bus.ack_s & sel_q);

  always_comb begin
    rd_pick = '0;
    for (int i = 0; i < SLAVE_N; i++) begin
      if (sel_q[i]) rd_pick = rd_pick | bus.rd_s[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      req_s_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      rd_q    <= '0;
`ifdef NF_ROUTER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_m && one_hot) begin
            addr_q  <= bus.addr_m;
            we_q    <= bus.we_m;
            wd_q    <= bus.wd_m;
            sel_q   <= bus.slave_sel;
            req_s_q <= bus.slave_sel;
            state_q <= BUSY;
`ifdef NF_ROUTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else if (bus.req_m) begin
            rd_q    <= ERR_RDATA;
            state_q <= ERR;
          end
        end
        BUSY: begin
          if (ack_hit) begin
            rd_q    <= rd_pick;
            req_s_q <= '0;
            state_q <= RESP;
`ifdef NF_ROUTER_TIMEOUT_EN
          // 255th unacked cycle: give up and answer with an error
          end else if (cnt_q == 8'd254) begin
            rd_q    <= ERR_RDATA;
            req_s_q <= '0;
            state_q <= ERR;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
`endif
          end
        end
        RESP:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack_m  = (state_q == RESP) || (state_q == ERR);
  assign bus.err_m  = (state_q == ERR);
  assign bus.rd_m   = rd_q;
  assign bus.addr_s = addr_q;
  assign bus.we_s   = we_q;
  assign bus.wd_s   = wd_q;
  assign bus.req_s  = req_s_q;

endmodule

// File: tb/tb_nf_router_ctrl.sv
// tb_nf_router_ctrl: random master/slave traffic with a scoreboard.
// Expected responses are queued at issue and popped on ack_m.
module tb_nf_router_ctrl;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          dly;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  nf_router_ctrl_if #(.SLAVE_N(4)) bus ();

  nf_router_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  logic [31:0] slave_data [4];
  int          resp_delay = 0;
  logic [3:0]  cur_sel = '0;
  logic [31:0] cur_addr = '0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_wd = '0;

  assign bus.rd_s = {slave_data[3], slave_data[2],
                     slave_data[1], slave_data[0]};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: ack the requested slave after resp_delay cycles,
  // sprinkle acks on other slaves at random.
  initial begin
    int   cnt;
    bit   active;
    logic [3:0] ack;
    cnt = 0;
    active = 0;
    bus.ack_s = '0;
    forever begin
      @(negedge clk);
      ack = '0;
      if (bus.req_s == '0) begin
        active = 0;
      end else begin
        if (!active) begin
          active = 1;
          cnt = resp_delay;
        end
        if (cnt == 0) ack = bus.req_s;
        else cnt--;
      end
      if ($urandom_range(0, 2) == 0)
        ack = ack | (4'($urandom) & ~bus.req_s);
      bus.ack_s = ack;
    end
  end

  // Monitor: slave-side bus checks and response scoreboard.
  initial begin
    int   req_cycles;
    exp_t e;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        req_cycles = 0;
      end else begin
        if (bus.req_s != '0) begin
          req_cycles++;
          chk("req_s", 32'(bus.req_s), 32'(cur_sel));
          chk("addr_s", bus.addr_s, cur_addr);
          chk("we_s", 32'(bus.we_s), 32'(cur_we));
          chk("wd_s", bus.wd_s, cur_wd);
        end
        if (bus.ack_m) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(bus.ack_m), 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("err_m", 32'(bus.err_m), 32'(e.err));
            chk("rd_m", bus.rd_m, e.rd);
            if (!e.err)
              chk("req_s_cycles", 32'(req_cycles), 32'(e.dly + 1));
            else
              chk("err_no_req", 32'(req_cycles), 32'h0);
          end
          req_cycles = 0;
        end
      end
    end
  end

  task automatic txn(input logic [3:0] sel, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int dly);
    exp_t e;
    int   waited;
    int   idx;
    bit   oh;
    oh  = ($countones(sel) == 1);
    idx = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
    resp_delay = dly;
    cur_sel  = oh ? sel : 4'b0000;
    cur_addr = addr;
    cur_we   = we;
    cur_wd   = wd;
    e.err = !oh;
    e.rd  = oh ? slave_data[idx] : 32'h0;
    e.dly = dly;
    exp_q.push_back(e);
    bus.addr_m    = addr;
    bus.we_m      = we;
    bus.wd_m      = wd;
    bus.slave_sel = sel;
    bus.req_m     = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.ack_m && waited < 400);
    chk("ack_latency", 32'(waited), oh ? 32'(dly + 2) : 32'd1);
    bus.req_m = 1'b0;
    @(negedge clk);
    if ($urandom_range(0, 1) == 1) @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) slave_data[i] = $urandom;
  endtask

  initial begin
    logic [3:0] sel;
    int a;
    int b;
    bus.addr_m = '0;
    bus.we_m = 1'b0;
    bus.wd_m = '0;
    bus.req_m = 1'b0;
    bus.slave_sel = '0;
    rand_data();
    repeat (2) @(negedge clk);
    chk("rst_ack_m", 32'(bus.ack_m), 32'h0);
    chk("rst_err_m", 32'(bus.err_m), 32'h0);
    chk("rst_req_s", 32'(bus.req_s), 32'h0);
    chk("rst_rd_m", bus.rd_m, 32'h0);
    chk("rst_addr_s", bus.addr_s, 32'h0);
    chk("rst_wd_s", bus.wd_s, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    slave_data[1] = 32'h1234_5678;
    txn(4'b0010, 1'b0, 32'h0001_0004, 32'h0, 0);
    txn(4'b0001, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 5);
    txn(4'b0000, 1'b0, 32'h0003_0000, 32'h0, 0);
    txn(4'b0110, 1'b0, 32'h0003_0004, 32'h0, 0);
    slave_data[1] = 32'hCAFE_0001;
    txn(4'b0010, 1'b0, 32'h0001_0008, 32'h0, 7);

    // Abort a BUSY transaction with an asynchronous reset.
    resp_delay = 30;
    cur_sel = 4'b0100;
    cur_addr = 32'h0002_0000;
    cur_we = 1'b1;
    cur_wd = 32'h0BAD_F00D;
    bus.addr_m = cur_addr;
    bus.we_m = cur_we;
    bus.wd_m = cur_wd;
    bus.slave_sel = cur_sel;
    bus.req_m = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_req_s", 32'(bus.req_s), 32'h4);
    #2 resetn = 1'b0;
    bus.req_m = 1'b0;
    #1;
    chk("arst_req_s", 32'(bus.req_s), 32'h0);
    chk("arst_ack_m", 32'(bus.ack_m), 32'h0);
    chk("arst_addr_s", bus.addr_s, 32'h0);
    chk("arst_we_s", 32'(bus.we_s), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rand_data();
    txn(4'b1000, 1'b0, 32'h0004_0000, 32'h0, 1);

    for (int n = 0; n < 60; n++) begin
      rand_data();
      a = $urandom_range(0, 9);
      if (a < 7) begin
        sel = 4'b0001 << $urandom_range(0, 3);
      end else if (a == 7) begin
        sel = 4'b0000;
      end else begin
        a = $urandom_range(0, 3);
        b = (a + $urandom_range(1, 3)) % 4;
        sel = (4'b0001 << a) | (4'b0001 << b);
      end
      txn(sel, 1'($urandom), $urandom, $urandom,
          $urandom_range(0, 8));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/nf_router_ctrl.md
Name: nf_router_ctrl

Overview:
- Sequential routing stage directly downstream of the load/store address decoder.
- Takes the one-hot `slave_sel` produced for the master address and latches one load/store transaction (address, write-enable, write data, target slave).
- Drives a req/ack handshake to the selected slave and returns that slave's read data and an ack to the master.
- Unmapped or non-one-hot selects are terminated locally with an error response, so the master never hangs.

Parameters:
- Slave_n, `SLAVE_NUMBER (4): number of slave ports; width of `slave_sel`, `req_s` and `ack_s`.
- ERR_RDATA, 32'h0000_0000: read data returned on an error response.

Ports:
- clk        input   1            system clock
- resetn     input   1            asynchronous active-low reset
- addr_m     input   32           master address
- we_m       input   1            master write enable (1 = store, 0 = load)
- wd_m       input   32           master write data
- req_m      input   1            master request; held stable until `ack_m`
- ack_m      output  1            master acknowledge, one-cycle pulse
- rd_m       output  32           read data to master, valid when `ack_m` = 1
- err_m      output  1            error flag, valid only with `ack_m`
- slave_sel  input   Slave_n      one-hot slave select from the address decoder for `addr_m`
- addr_s     output  32           latched address, broadcast to all slaves
- we_s       output  1            latched write enable, broadcast
- wd_s       output  32           latched write data, broadcast
- req_s      output  Slave_n      per-slave request, at most one bit set
- ack_s      input   Slave_n      per-slave acknowledge
- rd_s       input   32*Slave_n   concatenated slave read data; slave i occupies bits [32*i +: 32]

Behaviour:
- Reset (`resetn` low, asynchronous, any state including mid-transaction):
  - state = IDLE
  - `req_s`, `ack_m`, `err_m` = 0
  - `rd_m`, `addr_s`, `wd_s` = 0; `we_s` = 0
  - latched select = 0
  - A slave ack arriving during reset is ignored.
- States: IDLE, BUSY, RESP, ERR.
- IDLE:
  - `req_m` = 0: stay in IDLE.
  - `req_m` = 1 and `slave_sel` exactly one-hot: latch `addr_m`/`we_m`/`wd_m` into `addr_s`/`we_s`/`wd_s`, latch `slave_sel`, go to BUSY.
  - `req_m` = 1 and `slave_sel` zero or multi-hot: go to ERR.
- BUSY:
  - `req_s` = latched select; other bits stay 0.
  - Only the `ack_s` bit of the latched slave is observed; acks on other bits are ignored.
  - On latched ack: capture the matching `rd_s` slice into `rd_m`, drop `req_s` next cycle, go to RESP.
- RESP: `ack_m` = 1, `err_m` = 0 for exactly one cycle, then IDLE.
- ERR: `ack_m` = 1, `err_m` = 1, `rd_m` = ERR_RDATA for exactly one cycle; no `req_s` is asserted; then IDLE.
- `ack_m` and `err_m` are decoded from registered state (glitch-free); `rd_m` is a register.
- Latency:
  - `req_m` sampled in cycle N gives `req_s` high in N+1.
  - Slave ack in cycle M gives `ack_m` in M+1.
  - Minimum load/store latency: 2 cycles (`req_m` edge to `ack_m`).
  - Error latency: 1 cycle.
- `req_m` is sampled only in IDLE. The master deasserts or changes `req_m` after seeing `ack_m`; RESP/ERR always return to IDLE, so back-to-back transactions have one idle cycle between acks.
- `rd_m` holds its last value until the next capture; it is undefined for stores, but the captured slice value is still returned.
- No outstanding-transaction queue; exactly one transaction in flight.

Optional Feature:
- Macro: NF_ROUTER_TIMEOUT_EN
- Enabled:
  - 8-bit counter cleared on entry to BUSY, increments each BUSY cycle without ack.
  - When the count reaches 255 with no ack, `req_s` drops and the block goes to ERR (`err_m` = 1, `rd_m` = ERR_RDATA).
  - An ack in the same cycle the count reaches 255 wins: normal RESP.
- Disabled: no counter; BUSY waits indefinitely for the slave ack.

Test Plan:
- Load, slave 1 acks in the first `req_s` cycle; `rd_s` slice 1 = 32'h1234_5678 -> `req_s` = 4'b0010 for one cycle, `ack_m` 2 cycles after `req_m`, `rd_m` = 32'h1234_5678, `err_m` = 0.
- Store to slave 0 (`addr_m` 32'h0000_0010, `wd_m` 32'hA5A5_A5A5), ack delayed 5 cycles -> `addr_s`/`wd_s`/`we_s` stable while BUSY, `req_s` = 4'b0001 for 6 cycles, single `ack_m` pulse.
- `slave_sel` = 0 (unmapped address 32'h0003_0000) -> `req_s` never asserted, next cycle `ack_m` = 1, `err_m` = 1, `rd_m` = 0.
- Spurious `ack_s` = 4'b0100 while BUSY on slave 1 -> ignored; completes only on `ack_s[1]`, `rd_m` taken from slice 1.
- `resetn` low during BUSY -> `req_s` = 0 immediately (asynchronous), no `ack_m`; after release, a new load completes normally.
- NF_ROUTER_TIMEOUT_EN defined, slave never acks -> `req_s` high for 255 cycles, then `ack_m` = 1, `err_m` = 1, `rd_m` = 0; ack at count 255 -> normal response instead.
